// File: rtl/random_decoder_if.sv
// random_decoder_if
//   Groups the decoder's request, lookup and result signals.
//   en_decode        start request (system -> decoder)
//   fibonacci_random codeword to decode (system -> decoder)
//   cnt_a            weight lookup address (decoder -> RAM_fibonacci)
//   mema             weight for cnt_a, combinational (RAM_fibonacci -> decoder)
//   output_binary    decoded value (decoder -> system)
//   decode_done      one-cycle result strobe (decoder -> system)
//   overflow         weight sum exceeded the output range (decoder -> system)
//   busy             scan in progress (decoder -> system)
//   master: system/RAM side; slave: decoder side.
interface random_decoder_if #(
   parameter int unsigned CODE_W = 64,
   parameter int unsigned OUT_W  = 16,
   parameter int unsigned ADDR_W = 10
);
   logic              en_decode;
   logic [CODE_W-1:0] fibonacci_random;
   logic [ADDR_W-1:0] cnt_a;
   logic [OUT_W-1:0]  mema;
   logic [OUT_W-1:0]  output_binary;
   logic              decode_done;
   logic              overflow;
   logic              busy;

   modport master (
      output en_decode, fibonacci_random, mema,
      input  cnt_a, output_binary, decode_done, overflow, busy
   );

   modport slave (
      input  en_decode, fibonacci_random, mema,
      output cnt_a, output_binary, decode_done, overflow, busy
   );
endinterface

// File: rtl/random_decoder.sv
// random_decoder
//   Sequential Fibonacci-codeword decoder. Scans the captured codeword one bit
//   per cycle, LSB first, fetching each bit's weight through cnt_a/mema and
//   summing the weights of set bits. Any Fibonacci representation is accepted,
//   not only the Zeckendorf form.
//   clk   system clock, rising edge
//   rst   asynchronous active-high reset
//   dec   slave side of random_decoder_if (request, lookup, result)
module random_decoder #(
   parameter int unsigned CODE_W    = 64,
   parameter int unsigned OUT_W     = 16,
   parameter int unsigned ADDR_W    = 10,
   parameter int unsigned BASE_ADDR = 0
) (
   input  logic             clk,
   input  logic             rst,
   random_decoder_if.slave  dec
);
   // Seven guard bits: CODE_W (<=128) full-scale weights cannot wrap.
   localparam int unsigned ACC_W = OUT_W + 7;
   localparam int unsigned IDX_W = (CODE_W > 1) ? $clog2(CODE_W) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CODE_W - 1);

   typedef enum logic [1:0] {
      IDLE,
      SCAN,
      DONE
   } state_t;

   state_t            state_q, state_d;
   logic [CODE_W-1:0] code_q, code_d;
   logic [ACC_W-1:0]  acc_q, acc_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic [OUT_W-1:0]  out_q, out_d;
   logic              ovf_q, ovf_d;
   logic [ADDR_W-1:0] cnt_a;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         code_q  <= '0;
         acc_q   <= '0;
         idx_q   <= '0;
         out_q   <= '0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         code_q  <= code_d;
         acc_q   <= acc_d;
         idx_q   <= idx_d;
         out_q   <= out_d;
         ovf_q   <= ovf_d;
      end
   end

   always_comb begin
      state_d = state_q;
      code_d  = code_q;
      acc_d   = acc_q;
      idx_d   = idx_q;
      out_d   = out_q;
      ovf_d   = ovf_q;
      case (state_q)
         IDLE: begin
            if (dec.en_decode) begin
               code_d  = dec.fibonacci_random;
               acc_d   = '0;
               ovf_d   = 1'b0;
               idx_d   = '0;
               state_d = SCAN;
            end
         end
         SCAN: begin
            // The codeword is shifted right, so bit idx always sits at bit 0.
            if (code_q[0]) begin
               acc_d = acc_q + ACC_W'(dec.mema);
            end
            code_d = code_q >> 1;
            if (idx_q == LAST_IDX) begin
               // Result is latched on DONE entry and includes the last bit.
               out_d   = acc_d[OUT_W-1:0];
               ovf_d   = |acc_d[ACC_W-1:OUT_W];
               state_d = DONE;
            end else begin
               idx_d = idx_q + IDX_W'(1);
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_comb begin
      cnt_a = ADDR_W'(BASE_ADDR);
      if (state_q == SCAN) begin
         cnt_a = ADDR_W'(BASE_ADDR) + ADDR_W'(idx_q);
      end
   end

   assign dec.cnt_a         = cnt_a;
   assign dec.output_binary = out_q;
   assign dec.overflow      = ovf_q;
   assign dec.decode_done   = (state_q == DONE);
   assign dec.busy          = (state_q == SCAN);
endmodule

// File: tb/tb_random_decoder.sv
// tb_random_decoder
//   Self-checking bench for random_decoder. Models RAM_fibonacci as a
//   combinational weight table, builds randomised Fibonacci codewords, and
//   compares decoder results against a sum-of-weights reference.
module tb_random_decoder;
   localparam int unsigned CODE_W    = 64;
   localparam int unsigned OUT_W     = 16;
   localparam int unsigned ADDR_W    = 10;
   localparam int unsigned BASE_ADDR = 0;

   logic clk;
   logic rst;
   int   checks;
   int   errors;

   longint unsigned fib_full [CODE_W];
   logic [OUT_W-1:0] fib_w   [CODE_W];

   random_decoder_if #(.CODE_W(CODE_W), .OUT_W(OUT_W), .ADDR_W(ADDR_W)) ifc ();

   random_decoder #(
      .CODE_W   (CODE_W),
      .OUT_W    (OUT_W),
      .ADDR_W   (ADDR_W),
      .BASE_ADDR(BASE_ADDR)
   ) dut (
      .clk(clk),
      .rst(rst),
      .dec(ifc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // RAM_fibonacci: combinational, entries beyond the table read as zero.
   function automatic logic [OUT_W-1:0] ram_read(input logic [ADDR_W-1:0] a);
      int unsigned off;
      off = int'(a) - int'(BASE_ADDR);
      if (int'(a) >= int'(BASE_ADDR) && off < CODE_W) return fib_w[off];
      return '0;
   endfunction

   assign ifc.mema = ram_read(ifc.cnt_a);

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference: plain sum of table weights of the set bits.
   task automatic ref_decode(input logic [CODE_W-1:0] cw, output logic [OUT_W-1:0] val,
                             output logic ovf);
      longint unsigned sum;
      sum = 0;
      for (int i = 0; i < int'(CODE_W); i++) if (cw[i]) sum += fib_w[i];
      val = sum[OUT_W-1:0];
      ovf = (sum > 64'(2**OUT_W - 1));
   endtask

   // Zeckendorf form of v, then random splits w[k] -> w[k-1] + w[k-2].
   function automatic logic [CODE_W-1:0] rand_encode(input int unsigned v);
      logic [CODE_W-1:0] cw;
      longint unsigned rem;
      int unsigned k;
      cw  = '0;
      rem = v;
      for (int i = int'(CODE_W) - 1; i >= 0; i--) begin
         if (fib_full[i] <= rem) begin
            cw[i] = 1'b1;
            rem  -= fib_full[i];
         end
      end
      for (int t = 0; t < 24; t++) begin
         k = $urandom_range(2, 24);
         if (cw[k] && !cw[k-1] && !cw[k-2]) begin
            cw[k]   = 1'b0;
            cw[k-1] = 1'b1;
            cw[k-2] = 1'b1;
         end
      end
      return cw;
   endfunction

   // One decode; returns cycles from the start edge to decode_done (200 = timeout).
   task automatic run_decode(input logic [CODE_W-1:0] cw, output int lat,
                             output logic [OUT_W-1:0] val, output logic ovf,
                             output int addr_err);
      @(negedge clk);
      ifc.en_decode        = 1'b1;
      ifc.fibonacci_random = cw;
      lat      = 200;
      addr_err = 0;
      for (int n = 1; n < 200; n++) begin
         @(negedge clk);
         if (n == 1) begin
            ifc.en_decode        = 1'b0;
            ifc.fibonacci_random = ~cw;
         end
         if (n <= int'(CODE_W)) begin
            if (ifc.cnt_a !== ADDR_W'(BASE_ADDR + n - 1) || ifc.busy !== 1'b1) addr_err++;
         end
         if (ifc.decode_done === 1'b1) begin
            lat = n;
            break;
         end
      end
      val = ifc.output_binary;
      ovf = ifc.overflow;
   endtask

   task automatic decode_expect(input string tag, input logic [CODE_W-1:0] cw,
                                input logic [OUT_W-1:0] ev, input logic eo);
      int lat, aerr;
      logic [OUT_W-1:0] v;
      logic o;
      run_decode(cw, lat, v, o, aerr);
      check({tag, "_lat"}, 64'(lat), 64'(CODE_W + 1));
      check({tag, "_val"}, 64'(v), 64'(ev));
      check({tag, "_ovf"}, 64'(o), 64'(eo));
   endtask

   initial begin
      int lat, aerr, dones, t_prev, gaps_bad;
      logic [OUT_W-1:0] v, ev;
      logic o, eo;
      logic [CODE_W-1:0] cw;
      int unsigned rv;

      checks = 0;
      errors = 0;
      fib_full[0] = 1;
      fib_full[1] = 2;
      for (int i = 2; i < int'(CODE_W); i++) fib_full[i] = fib_full[i-1] + fib_full[i-2];
      for (int i = 0; i < int'(CODE_W); i++) fib_w[i] = fib_full[i][OUT_W-1:0];

      ifc.en_decode        = 1'b0;
      ifc.fibonacci_random = '0;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_cnt_a", 64'(ifc.cnt_a), 64'(BASE_ADDR));
      check("rst_out", 64'(ifc.output_binary), 64'd0);
      check("rst_done", 64'(ifc.decode_done), 64'd0);
      check("rst_ovf", 64'(ifc.overflow), 64'd0);
      check("rst_busy", 64'(ifc.busy), 64'd0);
      rst = 1'b0;

      // First decode: latency and lookup address walk.
      run_decode(64'h1, lat, v, o, aerr);
      check("one_lat", 64'(lat), 64'(CODE_W + 1));
      check("one_addr_walk", 64'(aerr), 64'd0);
      check("one_val", 64'(v), 64'd1);
      check("one_ovf", 64'(o), 64'd0);
      check("one_busy_done", 64'(ifc.busy), 64'd0);

      decode_expect("x5", 64'h5, 16'd4, 1'b0);
      decode_expect("x3", 64'h3, 16'd3, 1'b0);
      decode_expect("x4", 64'h4, 16'd3, 1'b0);
      decode_expect("zero", 64'h0, 16'd0, 1'b0);
      decode_expect("ovf", 64'h60_0000, 16'd9489, 1'b1);
      decode_expect("ovf_clr", 64'h1, 16'd1, 1'b0);

      // A request during SCAN is dropped.
      @(negedge clk);
      ifc.en_decode        = 1'b1;
      ifc.fibonacci_random = 64'h1;
      dones = 0;
      for (int n = 1; n <= 150; n++) begin
         @(negedge clk);
         ifc.en_decode = 1'b0;
         if (n == 10) begin
            ifc.en_decode        = 1'b1;
            ifc.fibonacci_random = 64'h2;
         end
         if (ifc.decode_done === 1'b1) begin
            dones++;
            check("drop_val", 64'(ifc.output_binary), 64'd1);
         end
      end
      check("drop_dones", 64'(dones), 64'd1);
      check("drop_idle", 64'(ifc.busy), 64'd0);

      // en_decode held high: back-to-back decodes every CODE_W+2 cycles.
      @(negedge clk);
      ifc.en_decode        = 1'b1;
      ifc.fibonacci_random = 64'h5;
      dones    = 0;
      t_prev   = 0;
      gaps_bad = 0;
      for (int n = 1; n <= 400 && dones < 3; n++) begin
         @(negedge clk);
         if (ifc.decode_done === 1'b1) begin
            if (dones > 0 && (n - t_prev) != int'(CODE_W) + 2) gaps_bad++;
            if (dones == 0 && n != int'(CODE_W) + 1) gaps_bad++;
            if (ifc.output_binary !== 16'd4) gaps_bad++;
            t_prev = n;
            dones++;
            if (dones == 3) ifc.en_decode = 1'b0;
         end
      end
      check("held_dones", 64'(dones), 64'd3);
      check("held_spacing", 64'(gaps_bad), 64'd0);
      repeat (2) @(negedge clk);
      check("held_stop", 64'(ifc.busy), 64'd0);

      // Reset during SCAN cycle 30.
      @(negedge clk);
      ifc.en_decode        = 1'b1;
      ifc.fibonacci_random = 64'h7;
      for (int n = 1; n <= 30; n++) begin
         @(negedge clk);
         ifc.en_decode = 1'b0;
      end
      rst = 1'b1;
      #1;
      check("mid_rst_busy", 64'(ifc.busy), 64'd0);
      check("mid_rst_out", 64'(ifc.output_binary), 64'd0);
      check("mid_rst_cnt_a", 64'(ifc.cnt_a), 64'(BASE_ADDR));
      check("mid_rst_done", 64'(ifc.decode_done), 64'd0);
      @(negedge clk);
      rst   = 1'b0;
      dones = 0;
      for (int n = 0; n < 80; n++) begin
         @(negedge clk);
         if (ifc.decode_done === 1'b1) dones++;
      end
      check("mid_rst_no_done", 64'(dones), 64'd0);
      decode_expect("after_rst", 64'h5, 16'd4, 1'b0);

      // Randomised non-unique encodings of random values.
      for (int i = 0; i < 1000; i++) begin
         rv = $urandom_range(0, 65535);
         cw = rand_encode(rv);
         run_decode(cw, lat, v, o, aerr);
         check("sweep_lat", 64'(lat), 64'(CODE_W + 1));
         check("sweep_val", 64'(v), 64'(rv));
         check("sweep_ovf", 64'(o), 64'd0);
      end

      // Arbitrary 64-bit codewords against the sum-of-weights model.
      for (int i = 0; i < 40; i++) begin
         cw = {$urandom, $urandom};
         ref_decode(cw, ev, eo);
         run_decode(cw, lat, v, o, aerr);
         check("raw_val", 64'(v), 64'(ev));
         check("raw_ovf", 64'(o), 64'(eo));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
